pc_sequencer: RTL

//  Fetch-stage controller driving the PC register's branchTaken/stall/offset inputs.

---
 rtl/pc_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: merges branch redirects, load-use hazards and imem wait states
// into one PC command per cycle, generates pipeline flushes and keeps saturating perf counters.
module pc_sequencer #(
  parameter int BOOT_CYCLES = 4,
  parameter int SHADOW      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic             imem_ready,
  input  logic             br_resolved,
  input  logic             br_taken,
  input  logic [31:0]      br_offset,
  output logic             branch_taken,
  output logic             stall,
  output logic [31:0]      branch_pc_offset,
  output logic             if_id_flush,
  output logic             if_id_hold,
  output logic             id_ex_flush,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int SW = $clog2(SHADOW + 1);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;
  localparam logic [1:0] ST_SHADOW = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] boot_cnt;
  logic [SW-1:0] shadow_cnt;
  logic          redirect;
  logic          hold;

  assign hold = hazard_stall | ~imem_ready;

  // Command outputs are zero-latency; reset forces the PC to hold even before the first edge.
  always_comb begin
    redirect         = 1'b0;
    branch_taken     = 1'b0;
    stall            = 1'b0;
    branch_pc_offset = 32'd0;
    if_id_flush      = 1'b0;
    if_id_hold       = 1'b0;
    id_ex_flush      = 1'b0;
    fetch_valid      = 1'b0;
    if (!rst_n || state == ST_BOOT) begin
      stall = 1'b1;
    end else begin
      // Branches resolving in the shadow belong to the wrong path.
      redirect = br_resolved & br_taken & (state != ST_SHADOW);
      if (redirect) begin
        branch_taken     = 1'b1;
        branch_pc_offset = br_offset;
        if_id_flush      = 1'b1;
        id_ex_flush      = 1'b1;
      end else if (hold) begin
        stall       = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        fetch_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      boot_cnt   <= BW'(BOOT_CYCLES);
      shadow_cnt <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BW'(1)) state <= ST_RUN;
          else                    boot_cnt <= boot_cnt - BW'(1);
        end
        ST_RUN, ST_STALL: begin
          if (redirect) begin
            state      <= ST_SHADOW;
            shadow_cnt <= SW'(SHADOW);
          end else if (hold) begin
            state <= ST_STALL;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          // Shadow length counts only cycles that actually fetched.
          if (!hold) begin
            if (shadow_cnt == SW'(1)) state <= ST_RUN;
            else                      shadow_cnt <= shadow_cnt - SW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (stall && state != ST_BOOT && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (branch_taken && redirect_count != {CNT_W{1'b1}})
        redirect_count <= redirect_count + CNT_W'(1);
    end
  end

endmodule
